// File: rtl/mem_burst_pkg.sv
// Shared types and default widths for the mem_burst_ctrl SRAM burst sequencer.
package mem_burst_pkg;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_ADDR_WIDTH    = 10;
  localparam int DEF_LEN_WIDTH     = 8;
  localparam int DEF_RD_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_TURN
  } state_t;

  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_LEN_WIDTH-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/mem_burst_rd_fifo.sv
// First-word-fall-through read-return buffer; push and pop together on a full FIFO is legal.
module mem_burst_rd_fifo #(
  parameter int DATA_WIDTH    = 16,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [DATA_WIDTH-1:0]            push_data,
  input  logic                             pop,
  output logic [DATA_WIDTH-1:0]            pop_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(RD_FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(RD_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] store [RD_FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           cnt;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(RD_FIFO_DEPTH));
  assign count    = cnt;
  assign pop_data = store[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of a single-port synchronous SRAM; all mem_* outputs are flopped.
// Define MEM_BURST_CTRL_PERF_EN to add saturating beat/stall performance counters.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int RD_FIFO_DEPTH = DEF_RD_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Handshakes: a transfer happens on the rising edge where valid && ready are both
  // high; the source holds its payload stable while valid is high and ready is low.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_data_oe,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  busy
`ifdef MEM_BURST_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_wr_beats,
  output logic [31:0]           perf_rd_beats,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [LEN_WIDTH-1:0]  rem_q, rem_nxt;
  logic                  run_q;
  logic                  beat_p1, beat_p2;
  logic                  cs_nxt, we_nxt, oe_nxt, doe_nxt;
  logic [ADDR_WIDTH-1:0] maddr_nxt;
  logic [DATA_WIDTH-1:0] mdata_nxt;
  logic                  wr_beat, rd_issue;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           outstanding;
  logic                  can_issue;

  // run_q keeps cmd_ready low while reset is asserted even though state is IDLE.
  assign cmd_ready = run_q && (state == ST_IDLE);
  assign wr_ready  = (state == ST_WRITE);
  assign busy      = (state != ST_IDLE);
  assign rd_valid  = !fifo_empty;

  // Beats in the SRAM pipeline already own a FIFO slot, so the FIFO cannot overflow.
  assign outstanding = {1'b0, fifo_count} + (CW+1)'(beat_p1) + (CW+1)'(beat_p2);
  assign can_issue   = !fifo_full && (outstanding < (CW+1)'(RD_FIFO_DEPTH));

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    cs_nxt    = 1'b0;
    we_nxt    = 1'b0;
    oe_nxt    = 1'b0;
    doe_nxt   = 1'b0;
    maddr_nxt = mem_addr;
    mdata_nxt = mem_data_o;
    wr_beat   = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_nxt  = cmd_addr;
          rem_nxt   = cmd_len;
          state_nxt = cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_valid) begin
          wr_beat   = 1'b1;
          cs_nxt    = 1'b1;
          we_nxt    = 1'b1;
          doe_nxt   = 1'b1;
          maddr_nxt = addr_q;
          mdata_nxt = wr_data;
          addr_nxt  = addr_q + 1'b1;
          rem_nxt   = rem_q - 1'b1;
          if (rem_q == '0) state_nxt = ST_TURN;
        end
      end
      ST_READ: begin
        if (can_issue) begin
          rd_issue  = 1'b1;
          cs_nxt    = 1'b1;
          oe_nxt    = 1'b1;
          maddr_nxt = addr_q;
          addr_nxt  = addr_q + 1'b1;
          rem_nxt   = rem_q - 1'b1;
          if (rem_q == '0) state_nxt = ST_DRAIN;
        end else if (beat_p1) begin
          // The SRAM returns the beat on the bus during this next cycle: keep it read-enabled.
          cs_nxt = 1'b1;
          oe_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        cs_nxt    = 1'b1;
        oe_nxt    = 1'b1;
        state_nxt = ST_TURN;
      end
      ST_TURN:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      run_q       <= 1'b0;
      beat_p1     <= 1'b0;
      beat_p2     <= 1'b0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      mem_data_oe <= 1'b0;
      mem_addr    <= '0;
      mem_data_o  <= '0;
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      rem_q       <= rem_nxt;
      run_q       <= 1'b1;
      beat_p1     <= rd_issue;
      beat_p2     <= beat_p1;
      mem_cs      <= cs_nxt;
      mem_we      <= we_nxt;
      mem_oe      <= oe_nxt;
      mem_data_oe <= doe_nxt;
      mem_addr    <= maddr_nxt;
      mem_data_o  <= mdata_nxt;
    end
  end

  // beat_p2 marks the cycle in which the registered SRAM data for an issued beat is on mem_data_i.
  mem_burst_rd_fifo #(
    .DATA_WIDTH    (DATA_WIDTH),
    .RD_FIFO_DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (beat_p2),
    .push_data (mem_data_i),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef MEM_BURST_CTRL_PERF_EN
  logic stall;
  assign stall = ((state == ST_WRITE) && !wr_beat) || ((state == ST_READ) && !rd_issue);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_wr_beats     <= '0;
      perf_rd_beats     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (wr_beat && (perf_wr_beats != '1))     perf_wr_beats     <= perf_wr_beats + 1'b1;
      if (rd_issue && (perf_rd_beats != '1))    perf_rd_beats     <= perf_rd_beats + 1'b1;
      if (stall && (perf_stall_cycles != '1))   perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: SRAM model, driver tasks, queue scoreboards and a negedge monitor.
module tb_mem_burst_ctrl;
  import mem_burst_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 8;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          mem_cs, mem_we, mem_oe, mem_data_oe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int rd_mode = 0;
  int rd_beats = 0;
  int first_rd_cyc = 0;
  int last_rd_cyc = 0;

  logic [DW-1:0]    exp_q[$];
  logic [AW+DW-1:0] wr_exp_q[$];

  logic          prev_hold;
  logic [DW-1:0] prev_data;
  logic          prev_rd;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  mem_burst_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .mem_cs      (mem_cs),
    .mem_we      (mem_we),
    .mem_oe      (mem_oe),
    .mem_addr    (mem_addr),
    .mem_data_o  (mem_data_o),
    .mem_data_oe (mem_data_oe),
    .mem_data_i  (mem_data_i),
    .busy        (busy)
  );

  // ---------------- SRAM model (registered read data) ----------------
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [DW-1:0] sram_q;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_data_o;
      else        sram_q <= sram[mem_addr];
    end
  end
  assign mem_data_i = mem_oe ? sram_q : '0;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- sink ready pattern ----------------
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((cyc % 3) == 0);
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("bus_dir", {31'b0, mem_oe & mem_data_oe}, 32'd0);
      if (mem_cs && mem_we) begin
        check("turnaround", {31'b0, prev_rd}, 32'd0);
        if (wr_exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wr_unexpected: got addr %h data %h expected no write", mem_addr, mem_data_o);
        end else begin
          logic [AW+DW-1:0] e;
          e = wr_exp_q.pop_front();
          check("wr_addr", {22'b0, mem_addr}, {22'b0, e[AW+DW-1:DW]});
          check("wr_data", {16'b0, mem_data_o}, {16'b0, e[DW-1:0]});
        end
      end
      if (prev_hold && rd_valid) check("rd_hold", {16'b0, rd_data}, {16'b0, prev_data});
      if (rd_valid && rd_ready) begin
        if (rd_beats == 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        rd_beats++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_unexpected: got %h expected no beat", rd_data);
        end else begin
          logic [DW-1:0] d;
          d = exp_q.pop_front();
          check("rd_data", {16'b0, rd_data}, {16'b0, d});
        end
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      prev_rd   = mem_cs && mem_oe;
    end else begin
      prev_hold = 1'b0;
      prev_rd   = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    cmd_t c;
    int   t;
    c = '{write: w, addr: a, len: l};
    t = 0;
    cmd_valid = 1'b1;
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_len   = c.len;
    while (!cmd_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("cmd_timeout", {31'b0, t >= 200}, 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input logic [DW-1:0] base, input int n,
                          input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      logic [AW-1:0] held;
      int t;
      a    = addr + AW'(i);
      held = a - 1'b1;
      if (i == gap_at) begin
        wr_valid = 1'b0;
        for (int k = 0; k < gap_len; k++) begin
          @(posedge clk);
          @(negedge clk);
          check("gap_cs", {31'b0, mem_cs}, 32'd0);
          check("gap_addr", {22'b0, mem_addr}, {22'b0, held});
        end
      end
      wr_exp_q.push_back({a, base + DW'(i)});
      wr_valid = 1'b1;
      wr_data  = base + DW'(i);
      t = 0;
      while (!wr_ready && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("wr_timeout", {31'b0, t >= 100}, 32'd0);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic expect_rd(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + DW'(i));
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || wr_exp_q.size() != 0 || busy) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, {31'b0, t >= 500}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int t;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_mode   = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {24'b0, cmd_ready, wr_ready, rd_valid, busy, mem_cs, mem_we, mem_oe, mem_data_oe}, 32'd0);
    check("rst_addr", {22'b0, mem_addr}, 32'd0);
    check("rst_data", {16'b0, mem_data_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // write then read, full-rate readback
    send_cmd(1'b1, 10'h010, 8'd3);
    wr_burst(10'h010, 16'hA000, 4, -1, 0);
    wait_done("t1w_timeout");
    rd_beats = 0;
    expect_rd(16'hA000, 4);
    send_cmd(1'b0, 10'h010, 8'd3);
    wait_done("t1r_timeout");
    check("t1_beats", rd_beats, 32'd4);
    check("t1_span", last_rd_cyc - first_rd_cyc, 32'd3);

    // address wrap 0x3FE -> 0x001
    send_cmd(1'b1, 10'h3FE, 8'd3);
    wr_burst(10'h3FE, 16'hB000, 4, -1, 0);
    wait_done("wrap_w_timeout");
    expect_rd(16'hB000, 4);
    send_cmd(1'b0, 10'h3FE, 8'd3);
    wait_done("wrap_r_timeout");

    // write with a 2-cycle gap before beat 3
    send_cmd(1'b1, 10'h100, 8'd5);
    wr_burst(10'h100, 16'hC000, 6, 3, 2);
    wait_done("gap_w_timeout");
    expect_rd(16'hC000, 6);
    send_cmd(1'b0, 10'h100, 8'd5);
    wait_done("gap_r_timeout");

    // backpressure: rd_ready high one cycle in three
    send_cmd(1'b1, 10'h200, 8'd7);
    wr_burst(10'h200, 16'hD000, 8, -1, 0);
    wait_done("bp_w_timeout");
    rd_mode  = 1;
    rd_beats = 0;
    expect_rd(16'hD000, 8);
    send_cmd(1'b0, 10'h200, 8'd7);
    wait_done("bp_r_timeout");
    check("bp_beats", rd_beats, 32'd8);
    rd_mode = 0;

    // read immediately followed by write
    expect_rd(16'hA000, 4);
    send_cmd(1'b0, 10'h010, 8'd3);
    send_cmd(1'b1, 10'h300, 8'd1);
    wr_burst(10'h300, 16'hE000, 2, -1, 0);
    wait_done("ta_timeout");
    expect_rd(16'hE000, 2);
    send_cmd(1'b0, 10'h300, 8'd1);
    wait_done("ta_r_timeout");

    // reset during beat 2 of an 8-beat read
    rd_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_cmd(1'b0, 10'h200, 8'd7);
    n = 0;
    t = 0;
    while (n < 3 && t < 50) begin
      @(negedge clk);
      if (mem_cs && mem_oe) n++;
      t++;
    end
    check("rst_beat_timeout", {31'b0, t >= 50}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {24'b0, cmd_ready, wr_ready, rd_valid, busy, mem_cs, mem_we, mem_oe, mem_data_oe}, 32'd0);
    check("midrst_addr", {22'b0, mem_addr}, 32'd0);
    check("midrst_data", {16'b0, mem_data_o}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("midrst_hold", {30'b0, mem_cs, rd_valid}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    rd_mode = 0;
    @(posedge clk);
    #1;
    check("post_rst_idle", {29'b0, mem_cs, rd_valid, busy}, 32'd0);
    expect_rd(16'hB000, 4);
    send_cmd(1'b0, 10'h3FE, 8'd3);
    wait_done("post_rst_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Burst sequencer sitting directly upstream of the single-port synchronous SRAM (cs/we/oe, registered read data, tri-stated data bus).
- Accepts write/read burst commands on a valid/ready interface.
- Streams write beats from a valid/ready source into the SRAM, and read beats out of it into a valid/ready sink.
- Generates every SRAM control, address and bus-direction signal.

Parameters:
- DATA_WIDTH, 16, SRAM word width.
- ADDR_WIDTH, 10, SRAM address width (depth 2^ADDR_WIDTH).
- LEN_WIDTH, 8, burst length field width.
- RD_FIFO_DEPTH, 4, read-return buffer depth; power of 2, at least 4.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  beats minus 1.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat consumed.
- wr_data  in  DATA_WIDTH  write beat.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  read beat taken.
- rd_data  out  DATA_WIDTH  read beat.
- mem_cs  out  1  SRAM chip select.
- mem_we  out  1  SRAM write enable.
- mem_oe  out  1  SRAM output enable.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_data_o  out  DATA_WIDTH  data driven onto the bus.
- mem_data_oe  out  1  bus drive enable; the top level ties data = mem_data_oe ? mem_data_o : 'z.
- mem_data_i  in  DATA_WIDTH  bus sampled value.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all mem_* outputs 0, cmd_ready 0, wr_ready 0, rd_valid 0, busy 0, FIFO empty, state IDLE.
- Reset mid-burst: the burst is abandoned, the FIFO is flushed, and no SRAM access occurs after reset asserts.
- Output timing: mem_* outputs are driven from flops, with no combinational path from any input to any mem_* output.
- States: IDLE, WRITE, READ, DRAIN, TURN.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch addr and remaining = cmd_len.
  - Go to WRITE if cmd_write, else READ.
- WRITE:
  - wr_ready = 1.
  - Each cycle with wr_valid, the next cycle presents mem_cs=1, mem_we=1, mem_oe=0, mem_data_oe=1, mem_addr = current address, mem_data_o = wr_data.
  - A cycle without wr_valid presents mem_cs=0 with address held.
  - After the beat with remaining == 0, go to TURN.
- READ:
  - Issuing a beat presents mem_cs=1, mem_we=0, mem_oe=1, mem_data_oe=0.
  - mem_data_i is sampled at the end of the following cycle and pushed to the FIFO.
  - In that following cycle cs/oe must stay high with we low. Either issue the next beat, or hold-read the same address.
  - Issue only when FIFO occupancy plus in-flight beats is below RD_FIFO_DEPTH; the FIFO must never overflow.
  - After issuing the beat with remaining == 0, go to DRAIN.
- DRAIN:
  - One hold-read cycle on the last address to capture the final beat.
  - Then go to TURN.
- TURN:
  - One cycle with all mem_* controls 0, as bus turnaround.
  - Then go to IDLE.
  - cmd_ready stays 0 until read FIFO outstanding beats = 0 is not required; commands may be accepted while the FIFO drains.
- Address arithmetic: address increments by 1 per issued beat and wraps modulo 2^ADDR_WIDTH (0x3FF to 0x000).
- Throughput: sustained 1 beat/cycle for writes with wr_valid held high, and for reads with rd_ready held high.
- Read FIFO output: rd_valid and rd_data are taken from the FIFO head, first-word fall-through.
- Simultaneous push and pop on a full FIFO is legal.
- rd_data holds stable while rd_valid && !rd_ready.

Optional Feature:
- Macro: MEM_BURST_CTRL_PERF_EN.
- When defined, adds outputs perf_wr_beats[31:0], perf_rd_beats[31:0] and perf_stall_cycles[31:0].
- perf_stall_cycles counts cycles in WRITE or READ with no beat issued.
- All three counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_burst_pkg holds:
  - state enum typedef (IDLE, WRITE, READ, DRAIN, TURN);
  - default width localparams;
  - a cmd_t struct {write, addr, len}.
- Sub-module mem_burst_rd_fifo: synchronous first-word-fall-through FIFO.
  - Parameters: DATA_WIDTH, RD_FIFO_DEPTH.
  - Ports: push, pop, full, empty, count.

Test Plan:
- Write then read: write burst addr 0x010, len 3 with data 0xA000..0xA003, then read burst same addr/len with rd_ready=1 -> rd_data sequence 0xA000..0xA003, 1 beat/cycle, exactly 4 rd_valid beats.
- Wrap: write addr 0x3FE, len 3 -> mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; readback matches.
- Backpressure: read len 7 with rd_ready toggling 1 of every 3 cycles -> no FIFO overflow, no lost or duplicated beats, order preserved.
- Write gaps: wr_valid deasserted for 2 cycles mid-burst -> mem_cs=0 in those cycles, address held, final contents correct.
- Turnaround: read command immediately followed by a write command -> at least 1 cycle with mem_cs=0 between the last read (DRAIN) cycle and the first write cycle, and mem_data_oe never 1 while mem_oe=1.
- Reset: assert rst_n=0 during beat 2 of an 8-beat read -> all outputs 0 asynchronously, FIFO empty, a subsequent command completes normally.
